// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one SRAM-like port between inst and data masters.
// In-order responses are routed back using a FIFO of accepted master ids.
module mem_req_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_inst_sram_req,
    input  logic        i_inst_sram_wr,
    input  logic [1:0]  i_inst_sram_size,
    input  logic [3:0]  i_inst_sram_wstrb,
    input  logic [31:0] i_inst_sram_addr,
    input  logic [31:0] i_inst_sram_wdata,
    output logic        o_inst_sram_addr_ok,
    output logic        o_inst_sram_data_ok,
    output logic [31:0] o_inst_sram_rdata,
    input  logic        i_data_sram_req,
    input  logic        i_data_sram_wr,
    input  logic [1:0]  i_data_sram_size,
    input  logic [3:0]  i_data_sram_wstrb,
    input  logic [31:0] i_data_sram_addr,
    input  logic [31:0] i_data_sram_wdata,
    output logic        o_data_sram_addr_ok,
    output logic        o_data_sram_data_ok,
    output logic [31:0] o_data_sram_rdata,
    output logic        o_mem_req,
    output logic        o_mem_wr,
    output logic [1:0]  o_mem_size,
    output logic [3:0]  o_mem_wstrb,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_addr_ok,
    input  logic        i_mem_data_ok,
    input  logic [31:0] i_mem_rdata,
    output logic        o_err_spurious_ok
);
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(MAX_OUTSTANDING);
    localparam logic [AW:0]   ONE  = (AW + 1)'(1);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_D = 2'd1,
        HOLD_I = 2'd2
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_ids [MAX_OUTSTANDING];
    logic [SW-1:0] r_starve;
    logic          r_err;

    logic w_empty;
    logic w_pop;
    logic w_full;
    logic w_head;
    logic w_pick_data;
    logic w_gnt_data;
    logic w_gnt_req;
    logic w_acc;

    // A pop in the same cycle frees a slot, so a full FIFO may still accept.
    assign w_empty = (r_count == '0);
    assign w_pop   = i_mem_data_ok && !w_empty && !i_reset;
    assign w_full  = (r_count == FULL) && !w_pop;
    assign w_head  = r_ids[r_rptr];

    // Data wins by default; a starved inst beats a competing data request.
    assign w_pick_data = i_data_sram_req &&
                         !(i_inst_sram_req && (r_starve >= SLIM));
    assign w_gnt_data  = (r_state == HOLD_D) ||
                         ((r_state == IDLE) && w_pick_data);
    assign w_gnt_req   = w_gnt_data ? i_data_sram_req : i_inst_sram_req;
    assign w_acc       = o_mem_req && i_mem_addr_ok;

    assign o_mem_req   = w_gnt_req && !w_full && !i_reset;
    assign o_mem_wr    = w_gnt_data ? i_data_sram_wr    : i_inst_sram_wr;
    assign o_mem_size  = w_gnt_data ? i_data_sram_size  : i_inst_sram_size;
    assign o_mem_wstrb = w_gnt_data ? i_data_sram_wstrb : i_inst_sram_wstrb;
    assign o_mem_addr  = w_gnt_data ? i_data_sram_addr  : i_inst_sram_addr;
    assign o_mem_wdata = w_gnt_data ? i_data_sram_wdata : i_inst_sram_wdata;

    assign o_inst_sram_addr_ok = w_acc && !w_gnt_data;
    assign o_data_sram_addr_ok = w_acc && w_gnt_data;
    assign o_inst_sram_data_ok = w_pop && !w_head;
    assign o_data_sram_data_ok = w_pop && w_head;
    assign o_inst_sram_rdata   = i_mem_rdata;
    assign o_data_sram_rdata   = i_mem_rdata;
    assign o_err_spurious_ok   = r_err;

    // Grant FSM: a stalled grant is held until the bridge accepts it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (o_mem_req && !i_mem_addr_ok)
                        r_state <= w_gnt_data ? HOLD_D : HOLD_I;
                end
                HOLD_D, HOLD_I: begin
                    if (w_acc || !w_gnt_req)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Order FIFO pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_acc)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            unique case ({w_acc, w_pop})
                2'b10:   r_count <= r_count + ONE;
                2'b01:   r_count <= r_count - ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Order FIFO storage: master id of each accepted request.
    always_ff @(posedge i_clk) begin
        if (w_acc)
            r_ids[r_wptr] <= w_gnt_data;
    end

    // Count cycles inst waits while requesting; saturates at the limit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_starve <= '0;
        end else if (!i_inst_sram_req || o_inst_sram_addr_ok) begin
            r_starve <= '0;
        end else if (w_gnt_data && (r_starve < SLIM)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Sticky flag for a response with nothing outstanding.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_err <= 1'b0;
        else if (i_mem_data_ok && w_empty)
            r_err <= 1'b1;
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: scoreboard bench for mem_req_arbiter.
// Expected response owners are queued as accepts are driven.
module tb_mem_req_arbiter;
    localparam logic [31:0] A_I = 32'h1000_0004;
    localparam logic [31:0] A_D = 32'h2000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ireq = 1'b0;
    logic        dreq = 1'b0;
    logic        aok = 1'b0;
    logic        dok = 1'b0;
    logic [31:0] rdata = '0;
    logic        i_aok, i_dok, d_aok, d_dok;
    logic [31:0] i_rd, d_rd;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic        err;

    int n_chk = 0;
    int n_err = 0;
    bit sb[$];

    always #5 clk = ~clk;

    mem_req_arbiter dut (
        .i_clk(clk), .i_reset(reset),
        .i_inst_sram_req(ireq), .i_inst_sram_wr(1'b0),
        .i_inst_sram_size(2'd2), .i_inst_sram_wstrb(4'h0),
        .i_inst_sram_addr(A_I), .i_inst_sram_wdata(32'h0),
        .o_inst_sram_addr_ok(i_aok), .o_inst_sram_data_ok(i_dok),
        .o_inst_sram_rdata(i_rd),
        .i_data_sram_req(dreq), .i_data_sram_wr(1'b1),
        .i_data_sram_size(2'd2), .i_data_sram_wstrb(4'hF),
        .i_data_sram_addr(A_D), .i_data_sram_wdata(32'hCAFE_0001),
        .o_data_sram_addr_ok(d_aok), .o_data_sram_data_ok(d_dok),
        .o_data_sram_rdata(d_rd),
        .o_mem_req(m_req), .o_mem_wr(m_wr), .o_mem_size(m_size),
        .o_mem_wstrb(m_wstrb), .o_mem_addr(m_addr), .o_mem_wdata(m_wdata),
        .i_mem_addr_ok(aok), .i_mem_data_ok(dok), .i_mem_rdata(rdata),
        .o_err_spurious_ok(err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs 1ns later.
    task automatic cyc(input bit ir, input bit dr, input bit ao, input bit dk,
                       input logic [31:0] rd, input bit e_req, input bit e_gd,
                       input bit e_ia, input bit e_da);
        bit e;
        @(negedge clk);
        ireq = ir; dreq = dr; aok = ao; dok = dk; rdata = rd;
        #1;
        check("mem_req", 32'(m_req), 32'(e_req));
        check("inst_addr_ok", 32'(i_aok), 32'(e_ia));
        check("data_addr_ok", 32'(d_aok), 32'(e_da));
        if (e_req) begin
            check("mem_addr", m_addr, e_gd ? A_D : A_I);
            check("mem_wr", 32'(m_wr), 32'(e_gd));
        end
        if (dk && sb.size() > 0) begin
            e = sb.pop_front();
            check("inst_data_ok", 32'(i_dok), 32'(!e));
            check("data_data_ok", 32'(d_dok), 32'(e));
            check("rdata", e ? d_rd : i_rd, rd);
        end else begin
            check("inst_data_ok_idle", 32'(i_dok), 32'h0);
            check("data_data_ok_idle", 32'(d_dok), 32'h0);
        end
        if (e_ia) sb.push_back(1'b0);
        if (e_da) sb.push_back(1'b1);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ireq = 1'b1; dreq = 1'b1; aok = 1'b1; dok = 1'b1;
        #1;
        check("rst_mem_req", 32'(m_req), 32'h0);
        check("rst_addr_ok", 32'({i_aok, d_aok}), 32'h0);
        check("rst_data_ok", 32'({i_dok, d_dok}), 32'h0);
        @(negedge clk);
        reset = 1'b0; ireq = 1'b0; dreq = 1'b0; aok = 1'b0; dok = 1'b0;
        #1;
        check("post_rst_count", 32'(dut.r_count), 32'h0);
        check("post_rst_state", 32'(dut.r_state), 32'h0);
        check("post_rst_err", 32'(err), 32'h0);
        check("post_rst_ok", 32'({i_aok, d_aok, i_dok, d_dok}), 32'h0);
        sb.delete();
    endtask

    initial begin
        do_reset();

        // Starvation: inst forced through every 9th cycle.
        for (int k = 0; k < 18; k++) begin
            bit gi;
            gi = (k % 9 == 8);
            cyc(1, 1, 1, k > 0, 32'(k), 1, !gi, gi, !gi);
        end
        cyc(0, 0, 0, 1, 32'h99, 0, 0, 0, 0);
        after_edge();
        check("starve_drain_count", 32'(dut.r_count), 32'h0);

        // Stalled data grant stays sticky while inst waits.
        for (int k = 0; k < 3; k++)
            cyc(1, 1, 0, 0, 32'h0, 1, 1, 0, 0);
        after_edge();
        check("hold_d_state", 32'(dut.r_state), 32'h1);
        cyc(1, 1, 1, 0, 32'h0, 1, 1, 0, 1);
        cyc(1, 0, 1, 1, 32'h55, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 32'h66, 0, 0, 0, 0);

        // Full FIFO blocks, then push+pop in one cycle.
        do_reset();
        for (int k = 0; k < 4; k++)
            cyc(1, 0, 1, 0, 32'h0, 1, 0, 1, 0);
        cyc(1, 0, 1, 0, 32'h0, 0, 0, 0, 0);
        after_edge();
        check("full_count", 32'(dut.r_count), 32'h4);
        cyc(1, 0, 1, 1, 32'hA5, 1, 0, 1, 0);
        after_edge();
        check("full_pushpop_count", 32'(dut.r_count), 32'h4);
        for (int k = 0; k < 4; k++)
            cyc(0, 0, 0, 1, 32'hB0 + 32'(k), 0, 0, 0, 0);
        after_edge();
        check("full_drain_count", 32'(dut.r_count), 32'h0);

        // Interleaved owners inst, data, data, inst.
        cyc(1, 0, 1, 0, 32'h0, 1, 0, 1, 0);
        cyc(0, 1, 1, 0, 32'h0, 1, 1, 0, 1);
        cyc(0, 1, 1, 0, 32'h0, 1, 1, 0, 1);
        cyc(1, 0, 1, 0, 32'h0, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 32'h11, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h22, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h33, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h44, 0, 0, 0, 0);
        after_edge();
        check("inter_count", 32'(dut.r_count), 32'h0);
        check("no_err_yet", 32'(err), 32'h0);

        // Spurious response on empty FIFO.
        cyc(0, 0, 0, 1, 32'h77, 0, 0, 0, 0);
        after_edge();
        check("spur_err", 32'(err), 32'h1);
        cyc(0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        check("spur_err_sticky", 32'(err), 32'h1);

        // Reset with 3 outstanding and inst grant held.
        do_reset();
        for (int k = 0; k < 3; k++)
            cyc(1, 0, 1, 0, 32'h0, 1, 0, 1, 0);
        cyc(1, 0, 0, 0, 32'h0, 1, 0, 0, 0);
        after_edge();
        check("hold_i_state", 32'(dut.r_state), 32'h2);
        check("hold_i_count", 32'(dut.r_count), 32'h3);
        do_reset();
        cyc(0, 0, 0, 1, 32'h88, 0, 0, 0, 0);
        after_edge();
        check("late_resp_err", 32'(err), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Shares one SRAM-like memory port between the instruction-fetch master and the data-access master of the pipeline; sits between the IF/EXE stages and the downstream bridge. It grants at most one address-phase request per cycle and records the master of each accepted request in an order FIFO. Each in-order response (`data_ok`) is routed back to the master that issued the request.

## Interface
- `MAX_OUTSTANDING`, 4: order-FIFO depth; must be a power of two, at least 2.
- `STARVE_LIMIT`, 8: consecutive cycles that inst can lose to data before inst is forced to win.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inst_sram_req/wr`  in  1 each  inst master request and write flag.
- `inst_sram_size`  in  2  inst access size.
- `inst_sram_wstrb`  in  4  inst byte-write strobes.
- `inst_sram_addr/wdata`  in  32 each  inst address and write data.
- `inst_sram_addr_ok/data_ok`  out  1 each  inst address accept and response valid.
- `inst_sram_rdata`  out  32  inst read data.
- `data_sram_*`: same set of ports for the data master.
- `mem_req/wr`  out  1 each  downstream request and write flag.
- `mem_size`  out  2  downstream access size.
- `mem_wstrb`  out  4  downstream byte-write strobes.
- `mem_addr/wdata`  out  32 each  downstream address and write data.
- `mem_addr_ok/data_ok`  in  1 each  downstream address accept and response valid.
- `mem_rdata`  in  32  downstream read data.
- `err_spurious_ok`  out  1  sticky flag: `mem_data_ok` arrived while the order FIFO was empty.

## Operation
- Grant FSM states:
  - IDLE: no grant held. Arbitrate each cycle.
  - HOLD_D: data master holds the grant.
  - HOLD_I: inst master holds the grant.
- IDLE arbitration:
  - Data wins by default.
  - Inst wins when `starve_cnt >= STARVE_LIMIT` and both masters request.
  - If only one master requests, that master wins.
  - No grant is issued when the FIFO is full (`count == MAX_OUTSTANDING`).
- A granted request that is not accepted that cycle (`mem_req && !mem_addr_ok`) moves the FSM to HOLD_x. The grant then stays sticky until `mem_addr_ok`, then returns to IDLE.
- Masters keep `req` and payload stable until `addr_ok`. The arbiter never switches a pending request to the other master.
- Payload mux: all `mem_*` request fields come from the granted master.
- `mem_req = granted_master_req && !fifo_full`. With no grant, `mem_req` is 0 and the other fields are don't-care.
- `x_sram_addr_ok = mem_addr_ok && mem_req && grant==x`. The non-granted master's `addr_ok` is always 0.
- Order FIFO:
  - Push the 1-bit master id (0 = inst, 1 = data) on `mem_req && mem_addr_ok`.
  - Pop on `mem_data_ok`, which routes the response to the head id: `x_sram_data_ok = mem_data_ok && head==x`.
  - Both `inst_sram_rdata` and `data_sram_rdata` are driven with `mem_rdata` every cycle.
- Push and pop in the same cycle leave `count` unchanged.
- A push is allowed when the FIFO is full and a pop occurs that same cycle.
- Pointers are log2(`MAX_OUTSTANDING`) bits wide and wrap modulo the depth. `count` is log2(`MAX_OUTSTANDING`)+1 bits wide.
- `mem_data_ok` with `count == 0`:
  - No `data_ok` is issued and there is no pop.
  - `err_spurious_ok` is set and stays set until reset.
- `starve_cnt` rules:
  - Increments when inst requests and is not granted.
  - Clears when inst is accepted or stops requesting.
  - Saturates at `STARVE_LIMIT`.
- Responses are assumed in order from downstream. Writes also return `data_ok` and use FIFO entries.

## Timing
- Request path is combinational, 0 cycles: `x_sram_req` to `mem_req` and `mem_addr_ok` to `x_sram_addr_ok` in the same cycle.
- Response routing is combinational, 0 cycles, from the FIFO head registered state.
- FSM, FIFO and `starve_cnt` update at the edge after the handshake.
- Reset (synchronous, takes effect mid-transaction too):
  - FSM goes to IDLE. Pointers, `count` and `starve_cnt` go to 0. `err_spurious_ok` goes to 0.
  - During the reset cycle and after it, `mem_req`, `inst_sram_addr_ok`, `data_sram_addr_ok`, `inst_sram_data_ok` and `data_sram_data_ok` are all 0.
  - In-flight responses after reset are treated as spurious.
- Throughput: one accepted request per cycle sustained, while the FIFO is not full.

## Test plan
- Both masters request every cycle, `mem_addr_ok` = 1, `STARVE_LIMIT` = 8:
  - Data is accepted on cycles 0–7.
  - Inst is accepted on cycle 8.
  - `starve_cnt` returns to 0 and the pattern repeats.
- Data request with `mem_addr_ok` low for 3 cycles while inst requests:
  - FSM stays in HOLD_D and `mem_addr` holds the data address.
  - `inst_sram_addr_ok` stays 0.
  - Data is accepted on the 4th cycle.
- Issue 4 inst reads and hold `mem_data_ok` = 0:
  - FIFO becomes full and `mem_req` drops on the 5th request.
  - On a cycle with `mem_data_ok` = 1, the 5th request is accepted in the same cycle and `count` stays at 4.
- Interleaved accepts inst, data, data, inst, then 4 responses with `mem_rdata` = 0x11, 0x22, 0x33, 0x44:
  - `data_ok` pulses go to inst, data, data, inst in that order, with the matching rdata.
- `mem_data_ok` pulse with an empty FIFO:
  - No `data_ok` to either master.
  - `err_spurious_ok` = 1 until reset.
- Assert `reset` for 1 cycle with 3 requests outstanding and HOLD_I active:
  - Next cycle: `count` = 0, FSM in IDLE, all `addr_ok`/`data_ok` outputs 0.
